// File: rtl/bicubic_mac.sv
// Bicubic 4x4 multiply-accumulate. Five-stage free-running pipeline that turns a
// pixel window and signed Q1.8 weights into one rounded, clamped pixel per cycle,
// and reports how many pixels were clamped in the last completed frame.
module bicubic_mac #(
   parameter int FRACTION_BITS = 8,
   parameter int COEFF_WIDTH   = 9,
   parameter int PIXEL_WIDTH   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic                      in_eol,
   input  logic [16*PIXEL_WIDTH-1:0] pix_win,
   input  logic [16*COEFF_WIDTH-1:0] coeff_mag,
   input  logic [15:0]               coeff_sign,
   output logic                      out_valid,
   output logic                      out_sof,
   output logic                      out_eol,
   output logic [PIXEL_WIDTH-1:0]    out_pix,
   output logic [15:0]               sat_cnt_frame
);

   localparam int UPROD_W = COEFF_WIDTH + PIXEL_WIDTH;
   localparam int PROD_W  = UPROD_W + 1;
   localparam int ROW_W   = PROD_W + 2;
   localparam int ACC_W   = ROW_W + 2;
   localparam int Q_W     = ACC_W - FRACTION_BITS;
   localparam logic [ACC_W-1:0] ROUND_C = ACC_W'(1) << (FRACTION_BITS - 1);

   logic [4:0]                vld_q, vld_d;
   logic [4:0]                sof_q, sof_d;
   logic [4:0]                eol_q, eol_d;

   logic [16*PIXEL_WIDTH-1:0] pix_s1_q, pix_s1_d;
   logic [16*COEFF_WIDTH-1:0] mag_s1_q, mag_s1_d;
   logic [15:0]               sign_s1_q, sign_s1_d;

   logic [UPROD_W-1:0]        uprod;
   logic [PROD_W-1:0]         uprod_ext;
   logic [PROD_W-1:0]         prod_q [16];
   logic [PROD_W-1:0]         prod_d [16];
   logic [ROW_W-1:0]          row_q [4];
   logic [ROW_W-1:0]          row_d [4];
   logic [ACC_W-1:0]          acc_q, acc_d;

   logic [Q_W-1:0]            q_mag;
   logic [PIXEL_WIDTH-1:0]    out_pix_q, out_pix_d;
   logic                      clamp_q, clamp_d;

   logic [15:0]               sat_cnt_q, sat_cnt_d;
   logic [15:0]               sat_frame_q, sat_frame_d;

   // Sideband shift: valid and frame markers march alongside the data, markers gated by valid
   always_comb begin
      vld_d = {vld_q[3:0], in_valid};
      sof_d = {sof_q[3:0], in_valid & in_sof};
      eol_d = {eol_q[3:0], in_valid & in_eol};
   end

   // Stage 1 capture of window, magnitudes and signs
   always_comb begin
      pix_s1_d  = pix_win;
      mag_s1_d  = coeff_mag;
      sign_s1_d = coeff_sign;
   end

   // Stage 2: sixteen unsigned products, negated into two's complement where the weight is negative
   always_comb begin
      uprod     = '0;
      uprod_ext = '0;
      for (int i = 0; i < 16; i++) begin
         uprod     = UPROD_W'(mag_s1_q[i*COEFF_WIDTH +: COEFF_WIDTH]) *
                     UPROD_W'(pix_s1_q[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
         uprod_ext = {1'b0, uprod};
         prod_d[i] = sign_s1_q[i] ? (PROD_W'(0) - uprod_ext) : uprod_ext;
      end
   end

   // Stage 3: per-row sums, sign-extended so four terms can never overflow
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < 4; c++) begin
            row_d[r] = row_d[r] + {{(ROW_W-PROD_W){prod_q[4*r+c][PROD_W-1]}}, prod_q[4*r+c]};
         end
      end
   end

   // Stage 4: total with the half-LSB bias folded in so the later shift rounds half-up
   always_comb begin
      acc_d = ROUND_C;
      for (int r = 0; r < 4; r++) begin
         acc_d = acc_d + {{(ACC_W-ROW_W){row_q[r][ACC_W-ROW_W > 0 ? ROW_W-1 : 0]}}, row_q[r]};
      end
   end

   // Stage 5: drop fraction bits and clamp; idle slots output zero so stale data never leaks
   always_comb begin
      q_mag     = acc_q[ACC_W-1:FRACTION_BITS];
      out_pix_d = '0;
      clamp_d   = 1'b0;
      if (vld_q[3]) begin
         if (acc_q[ACC_W-1]) begin
            out_pix_d = '0;
            clamp_d   = 1'b1;
         end else if (|q_mag[Q_W-1:PIXEL_WIDTH]) begin
            out_pix_d = '1;
            clamp_d   = 1'b1;
         end else begin
            out_pix_d = q_mag[PIXEL_WIDTH-1:0];
         end
      end
   end

   // Clamp counter: a start-of-frame pixel publishes the running count and restarts it
   always_comb begin
      sat_cnt_d   = sat_cnt_q;
      sat_frame_d = sat_frame_q;
      if (vld_q[4]) begin
         if (sof_q[4]) begin
            sat_frame_d = sat_cnt_q;
            sat_cnt_d   = {15'd0, clamp_q};
         end else if (clamp_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
         end
      end
   end

   // Control and output registers, cleared by reset so in-flight pixels are discarded
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q       <= '0;
         sof_q       <= '0;
         eol_q       <= '0;
         out_pix_q   <= '0;
         clamp_q     <= 1'b0;
         sat_cnt_q   <= '0;
         sat_frame_q <= '0;
      end else begin
         vld_q       <= vld_d;
         sof_q       <= sof_d;
         eol_q       <= eol_d;
         out_pix_q   <= out_pix_d;
         clamp_q     <= clamp_d;
         sat_cnt_q   <= sat_cnt_d;
         sat_frame_q <= sat_frame_d;
      end
   end

   // Datapath registers load every cycle; their contents only matter under a valid bit
   always_ff @(posedge clk) begin
      pix_s1_q  <= pix_s1_d;
      mag_s1_q  <= mag_s1_d;
      sign_s1_q <= sign_s1_d;
      prod_q    <= prod_d;
      row_q     <= row_d;
      acc_q     <= acc_d;
   end

   assign out_valid     = vld_q[4];
   assign out_sof       = sof_q[4];
   assign out_eol       = eol_q[4];
   assign out_pix       = out_pix_q;
   assign sat_cnt_frame = sat_frame_q;

endmodule

// File: tb/tb_bicubic_mac.sv
// Self-checking bench for bicubic_mac: an arithmetic model fills a scoreboard as
// pixels are launched, and each scenario task pops and compares as results emerge.
module tb_bicubic_mac;

   typedef struct {
      logic [7:0]  pix;
      logic        sof;
      logic        eol;
      int          cyc;
      logic [15:0] frame;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_sof, in_eol;
   logic [127:0] pix_win;
   logic [143:0] coeff_mag;
   logic [15:0]  coeff_sign;
   logic         out_valid, out_sof, out_eol;
   logic [7:0]   out_pix;
   logic [15:0]  sat_cnt_frame;

   logic [127:0] pw;
   logic [143:0] cm;
   logic [15:0]  cs;
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   int           m_cnt = 0;
   int           m_frame = 0;
   exp_t         sb_q[$];

   bicubic_mac #(.FRACTION_BITS(8), .COEFF_WIDTH(9), .PIXEL_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
      .pix_win(pix_win), .coeff_mag(coeff_mag), .coeff_sign(coeff_sign),
      .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
      .out_pix(out_pix), .sat_cnt_frame(sat_cnt_frame)
   );

   // 10-time-unit clock
   always #5 clk = ~clk;

   // Cycle counter used to check exact latency
   always @(posedge clk) cyc <= cyc + 1;

   task automatic clear_win();
      pw = '0;
      cm = '0;
      cs = '0;
   endtask

   task automatic set_elem(input int r, input int c, input int mag, input logic neg, input int px);
      int k;
      k = 4*r + c;
      cm[k*9 +: 9] = 9'(mag);
      cs[k]        = neg;
      pw[k*8 +: 8] = 8'(px);
   endtask

   // Drive one slot and, when it will be accepted, push the modelled result
   task automatic drive(input logic v, input logic s, input logic e);
      exp_t x;
      int   acc, term, q;
      logic clamp;
      in_valid   = v;
      in_sof     = s;
      in_eol     = e;
      pix_win    = pw;
      coeff_mag  = cm;
      coeff_sign = cs;
      if (v && !rst) begin
         acc = 128;
         for (int k = 0; k < 16; k++) begin
            term = int'(cm[k*9 +: 9]) * int'(pw[k*8 +: 8]);
            acc  = cs[k] ? acc - term : acc + term;
         end
         q       = acc >>> 8;
         clamp   = (q < 0) || (q > 255);
         x.pix   = (q < 0) ? 8'd0 : ((q > 255) ? 8'd255 : 8'(q));
         x.sof   = s;
         x.eol   = e;
         x.cyc   = cyc + 5;
         x.frame = 16'(m_frame);
         sb_q.push_back(x);
         if (s) begin
            m_frame = m_cnt;
            m_cnt   = clamp ? 1 : 0;
         end else if (clamp && m_cnt < 65535) begin
            m_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clear_win();
         set_elem(1, 1, 511, 1'b0, 255);
         drive(1'b1, 1'b1, 1'b1);
         @(posedge clk); #1;
         total++;
         if ({out_valid, out_sof, out_eol} !== 3'b000 || out_pix !== 8'd0 || sat_cnt_frame !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got valid=%b sof=%b eol=%b pix=%0d frame=%0d, want all 0",
                     out_valid, out_sof, out_eol, out_pix, sat_cnt_frame);
         end
      end
      rst = 1'b0;
      sb_q.delete();
      m_cnt   = 0;
      m_frame = 0;
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_leak: got out_valid=%b at cycle %0d, want 0", out_valid, cyc);
         end
      end
   endtask

   task automatic test_identity();
      exp_t x;
      for (int i = 0; i < 9; i++) begin
         clear_win();
         set_elem(1, 1, 256, 1'b0, 200);
         drive(i == 0, i == 0, 1'b0);
         @(posedge clk); #1;
         total++;
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL identity_extra: got out_valid=1 pix=%0d at cycle %0d, want none", out_pix, cyc);
            end else begin
               x = sb_q.pop_front();
               if (out_pix !== x.pix || out_sof !== x.sof || out_eol !== x.eol || cyc != x.cyc || sat_cnt_frame !== x.frame) begin
                  bad++;
                  $display("[TB] FAIL identity_out: got pix=%0d sof=%b eol=%b cyc=%0d frame=%0d, want pix=%0d sof=%b eol=%b cyc=%0d frame=%0d",
                           out_pix, out_sof, out_eol, cyc, sat_cnt_frame, x.pix, x.sof, x.eol, x.cyc, x.frame);
               end
            end
         end else if ({out_valid, out_sof, out_eol} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL identity_idle: got valid=%b sof=%b eol=%b, want 0", out_valid, out_sof, out_eol);
         end
      end
      total++;
      if (sb_q.size() != 0 || x.pix !== 8'd200) begin
         bad++;
         $display("[TB] FAIL identity_value: got pending=%0d last=%0d, want pending=0 last=200", sb_q.size(), x.pix);
      end
      sb_q.delete();
   endtask

   task automatic test_negative_lobe();
      exp_t x;
      for (int i = 0; i < 9; i++) begin
         clear_win();
         if (i == 0) begin
            for (int k = 0; k < 16; k++) pw[k*8 +: 8] = 8'd100;
            set_elem(0, 1, 16, 1'b1, 100);
            set_elem(1, 1, 272, 1'b0, 100);
         end else begin
            for (int k = 0; k < 16; k++) pw[k*8 +: 8] = 8'd255;
            set_elem(0, 1, 256, 1'b1, 255);
         end
         drive(i < 2, 1'b0, i == 1);
         @(posedge clk); #1;
         total++;
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL neglobe_extra: got out_valid=1 pix=%0d at cycle %0d, want none", out_pix, cyc);
            end else begin
               x = sb_q.pop_front();
               if (out_pix !== x.pix || out_sof !== x.sof || out_eol !== x.eol || cyc != x.cyc || sat_cnt_frame !== x.frame) begin
                  bad++;
                  $display("[TB] FAIL neglobe_out: got pix=%0d sof=%b eol=%b cyc=%0d frame=%0d, want pix=%0d sof=%b eol=%b cyc=%0d frame=%0d",
                           out_pix, out_sof, out_eol, cyc, sat_cnt_frame, x.pix, x.sof, x.eol, x.cyc, x.frame);
               end
            end
         end else if ({out_valid, out_sof, out_eol} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL neglobe_idle: got valid=%b sof=%b eol=%b, want 0", out_valid, out_sof, out_eol);
         end
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL neglobe_missing: got %0d outputs outstanding, want 0", sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_rounding();
      exp_t x;
      logic v;
      for (int i = 0; i < 34; i++) begin
         clear_win();
         v = 1'b1;
         if (i == 0) begin
            set_elem(1, 1, 128, 1'b0, 3);
         end else if (i == 1) begin
            set_elem(1, 1, 511, 1'b0, 255);
         end else if (i < 26) begin
            for (int k = 0; k < 16; k++) begin
               cm[k*9 +: 9] = 9'($urandom_range(0, 48));
               pw[k*8 +: 8] = 8'($urandom_range(0, 255));
            end
            cs = 16'($urandom);
            v  = ($urandom_range(0, 3) != 0);
         end else begin
            v = 1'b0;
         end
         drive(v, 1'b0, 1'b0);
         @(posedge clk); #1;
         total++;
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL rounding_extra: got out_valid=1 pix=%0d at cycle %0d, want none", out_pix, cyc);
            end else begin
               x = sb_q.pop_front();
               if (out_pix !== x.pix || out_sof !== x.sof || out_eol !== x.eol || cyc != x.cyc || sat_cnt_frame !== x.frame) begin
                  bad++;
                  $display("[TB] FAIL rounding_out: got pix=%0d sof=%b eol=%b cyc=%0d frame=%0d, want pix=%0d sof=%b eol=%b cyc=%0d frame=%0d",
                           out_pix, out_sof, out_eol, cyc, sat_cnt_frame, x.pix, x.sof, x.eol, x.cyc, x.frame);
               end
            end
         end else if ({out_valid, out_sof, out_eol} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL rounding_idle: got valid=%b sof=%b eol=%b, want 0", out_valid, out_sof, out_eol);
         end
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL rounding_missing: got %0d outputs outstanding, want 0", sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_sat_count();
      exp_t x;
      int   b_sof_out;
      logic clamped;
      b_sof_out = -10;
      for (int i = 0; i < 24; i++) begin
         clear_win();
         clamped = (i == 3) || (i == 5) || (i == 8) || (i == 10) || (i == 12) || (i == 15);
         if (clamped) set_elem(1, 1, 511, 1'b0, 255);
         else         set_elem(1, 1, 256, 1'b0, 20 + i);
         if (i == 10) b_sof_out = cyc + 5;
         drive(i < 17, (i == 0) || (i == 10) || (i == 14), (i == 9) || (i == 13) || (i == 16));
         @(posedge clk); #1;
         total++;
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL satcnt_extra: got out_valid=1 pix=%0d at cycle %0d, want none", out_pix, cyc);
            end else begin
               x = sb_q.pop_front();
               if (out_pix !== x.pix || out_sof !== x.sof || out_eol !== x.eol || cyc != x.cyc || sat_cnt_frame !== x.frame) begin
                  bad++;
                  $display("[TB] FAIL satcnt_out: got pix=%0d sof=%b eol=%b cyc=%0d frame=%0d, want pix=%0d sof=%b eol=%b cyc=%0d frame=%0d",
                           out_pix, out_sof, out_eol, cyc, sat_cnt_frame, x.pix, x.sof, x.eol, x.cyc, x.frame);
               end
            end
         end else if ({out_valid, out_sof, out_eol} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL satcnt_idle: got valid=%b sof=%b eol=%b, want 0", out_valid, out_sof, out_eol);
         end
         if (cyc == b_sof_out + 1) begin
            total++;
            if (sat_cnt_frame !== 16'd3) begin
               bad++;
               $display("[TB] FAIL satcnt_frame_a: got %0d, want 3", sat_cnt_frame);
            end
         end
      end
      total++;
      if (sat_cnt_frame !== 16'd2 || sb_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL satcnt_frame_b: got frame=%0d pending=%0d, want frame=2 pending=0", sat_cnt_frame, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_back_to_back();
      exp_t x;
      logic [3:0] vpat;
      vpat = 4'b1011;
      for (int i = 0; i < 11; i++) begin
         clear_win();
         set_elem(2, 2, 256, 1'b0, 10 * (i + 1));
         drive((i < 4) && vpat[i], 1'b0, i == 3);
         @(posedge clk); #1;
         total++;
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL b2b_extra: got out_valid=1 pix=%0d at cycle %0d, want none", out_pix, cyc);
            end else begin
               x = sb_q.pop_front();
               if (out_pix !== x.pix || out_sof !== x.sof || out_eol !== x.eol || cyc != x.cyc || sat_cnt_frame !== x.frame) begin
                  bad++;
                  $display("[TB] FAIL b2b_out: got pix=%0d sof=%b eol=%b cyc=%0d frame=%0d, want pix=%0d sof=%b eol=%b cyc=%0d frame=%0d",
                           out_pix, out_sof, out_eol, cyc, sat_cnt_frame, x.pix, x.sof, x.eol, x.cyc, x.frame);
               end
            end
         end else if ({out_valid, out_sof, out_eol} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL b2b_idle: got valid=%b sof=%b eol=%b, want 0", out_valid, out_sof, out_eol);
         end
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL b2b_missing: got %0d outputs outstanding, want 0", sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_midstream_reset();
      exp_t x;
      logic clamped;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin
            rst = 1'b1;
            sb_q.delete();
            m_cnt   = 0;
            m_frame = 0;
         end else begin
            rst = 1'b0;
         end
         clear_win();
         clamped = (i == 0) || (i == 4) || (i == 6);
         if (clamped) set_elem(3, 0, 511, 1'b0, 255);
         else         set_elem(3, 0, 256, 1'b0, 60 + i);
         drive(i < 13, (i == 0) || (i == 4) || (i == 10), 1'b0);
         @(posedge clk); #1;
         total++;
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL midrst_extra: got out_valid=1 pix=%0d at cycle %0d, want none", out_pix, cyc);
            end else begin
               x = sb_q.pop_front();
               if (out_pix !== x.pix || out_sof !== x.sof || out_eol !== x.eol || cyc != x.cyc || sat_cnt_frame !== x.frame) begin
                  bad++;
                  $display("[TB] FAIL midrst_out: got pix=%0d sof=%b eol=%b cyc=%0d frame=%0d, want pix=%0d sof=%b eol=%b cyc=%0d frame=%0d",
                           out_pix, out_sof, out_eol, cyc, sat_cnt_frame, x.pix, x.sof, x.eol, x.cyc, x.frame);
               end
            end
         end else if ({out_valid, out_sof, out_eol} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL midrst_idle: got valid=%b sof=%b eol=%b, want 0", out_valid, out_sof, out_eol);
         end
         if (i == 3) begin
            total++;
            if (sat_cnt_frame !== 16'd0) begin
               bad++;
               $display("[TB] FAIL midrst_frame_clear: got %0d, want 0", sat_cnt_frame);
            end
         end
      end
      total++;
      if (sb_q.size() != 0 || sat_cnt_frame !== 16'(m_frame)) begin
         bad++;
         $display("[TB] FAIL midrst_end: got pending=%0d frame=%0d, want pending=0 frame=%0d",
                  sb_q.size(), sat_cnt_frame, m_frame);
      end
      sb_q.delete();
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_sof     = 1'b0;
      in_eol     = 1'b0;
      pix_win    = '0;
      coeff_mag  = '0;
      coeff_sign = '0;
      clear_win();
      $display("[TB] bicubic_mac bench start");
      test_reset();
      test_identity();
      test_negative_lobe();
      test_rounding();
      test_sat_count();
      test_back_to_back();
      test_midstream_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
